// File: rtl/divisor_secuencial_pkg.sv
// Shared ALU definitions for the sequential divider: FSM state type and
// iteration-counter sizing helper.
package divisor_secuencial_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

  // Counter width for a divider of n-bit operands.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/divisor_secuencial_sumador.sv
// W-bit ripple adder with carry in/out; the divider uses it as a subtractor.
module divisor_secuencial_sumador #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/divisor_secuencial.sv
// N-bit unsigned restoring divider, one trial subtraction per RUN cycle,
// driven through a start/done handshake.
module divisor_secuencial
  import divisor_secuencial_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CW = cnt_width(N);
  localparam logic [CW-1:0] LastIter = CW'(N - 1);

  div_state_t    state;
  logic [N:0]    r;
  logic [N-1:0]  q;
  logic [N-1:0]  d;
  logic [CW-1:0] cnt;

  logic [N:0]    r_shift;
  logic [N:0]    t;
  logic          no_borrow;
  logic [N:0]    r_next;
  logic [N-1:0]  q_next;

  assign r_shift = {r[N-1:0], q[N-1]};

  // R' - D computed as R' + ~D + 1; carry-out set means R' >= D.
  divisor_secuencial_sumador #(
    .W (N + 1)
  ) u_sumador (
    .a    (r_shift),
    .b    (~{1'b0, d}),
    .cin  (1'b1),
    .sum  (t),
    .cout (no_borrow)
  );

  assign r_next = no_borrow ? t : r_shift;
  assign q_next = {q[N-2:0], no_borrow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r    <= '0;
            q    <= dividend;
            d    <= divisor;
            cnt  <= '0;
            busy <= 1'b1;
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          r   <= r_next;
          q   <= q_next;
          cnt <= cnt + CW'(1);
          if (cnt == LastIter) begin
            state       <= DONE;
            done        <= 1'b1;
            quotient    <= q_next;
            remainder   <= r_next[N-1:0];
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_secuencial.sv
// Self-checking bench for divisor_secuencial (N=4 and N=8 instances) using a
// scoreboard of expected results.
module tb_divisor_secuencial;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [3:0] quotient, remainder;

  logic       s8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       busy8, done8, z8;
  logic [7:0] q8, r8;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       z;
    int         lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  divisor_secuencial #(.N(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  divisor_secuencial #(.N(8)) dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (s8),
    .dividend    (a8),
    .divisor     (b8),
    .busy        (busy8),
    .done        (done8),
    .quotient    (q8),
    .remainder   (r8),
    .div_by_zero (z8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] a, input logic [3:0] b);
    int ai, bi;
    exp_t e;
    ai = int'(a);
    bi = int'(b);
    e.q   = (bi == 0) ? 4'hF : 4'(ai / bi);
    e.r   = (bi == 0) ? a : 4'(ai % bi);
    e.z   = (bi == 0);
    e.lat = (bi == 0) ? 0 : 4;
    sb.push_back(e);
  endtask

  task automatic cmp_result(input string tag, input int lat);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_lat"}, lat, e.lat);
      chk({tag, "_q"}, quotient, e.q);
      chk({tag, "_r"}, remainder, e.r);
      chk({tag, "_z"}, div_by_zero, e.z);
    end
  endtask

  // Drives a request and returns just after the accept edge.
  task automatic start_div(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    push_exp(a, b);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_on_accept", busy, 1'b1);
  endtask

  task automatic finish_div(input string tag);
    int lat;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_done_seen"}, done, 1'b1);
    cmp_result(tag, lat);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_busy_low"}, busy, 1'b0);
  endtask

  initial begin
    int ndone;
    int lat;

    // Reset state
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_q", quotient, 4'd0);
    chk("rst_r", remainder, 4'd0);
    chk("rst_z", div_by_zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic and directed operand pairs
    start_div(4'd13, 4'd3);  finish_div("d13_3");
    start_div(4'd15, 4'd1);  finish_div("d15_1");
    start_div(4'd2,  4'd9);  finish_div("d2_9");
    start_div(4'd15, 4'd15); finish_div("d15_15");

    // Divide by zero, then a normal division clears the flag
    start_div(4'd7, 4'd0);   finish_div("d7_0");
    start_div(4'd9, 4'd2);   finish_div("d9_2");

    // start held high through RUN and DONE with new operands: ignored
    @(negedge clk);
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    push_exp(4'd13, 4'd3);
    @(posedge clk);
    #1;
    dividend = 4'd6;
    divisor  = 4'd2;
    ndone = 0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        ndone++;
        cmp_result("ign", i);
      end
    end
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) ndone++;
    end
    chk("ign_single_done", ndone, 1);
    chk("ign_q_held", quotient, 4'd4);
    chk("ign_r_held", remainder, 4'd1);

    // Reset mid-division aborts it
    start_div(4'd13, 4'd3);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_q", quotient, 4'd0);
    chk("abort_r", remainder, 4'd0);
    chk("abort_z", div_by_zero, 1'b0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    start_div(4'd6, 4'd2); finish_div("d6_2");

    // Exhaustive sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        start_div(4'(a), 4'(b));
        finish_div("sweep");
      end
    end

    // N=8 instance
    @(negedge clk);
    a8 = 8'd200;
    b8 = 8'd7;
    s8 = 1'b1;
    @(posedge clk);
    #1;
    s8 = 1'b0;
    lat = 0;
    while (done8 !== 1'b1 && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("n8_lat", lat, 8);
    chk("n8_q", q8, 8'd28);
    chk("n8_r", r8, 8'd4);
    chk("n8_z", z8, 1'b0);
    @(posedge clk);
    #1;
    chk("n8_busy_low", busy8, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
